fsm_lect_ram: RTL and testbench

FSM_LECT_RAM -- requirements
Module: fsm_lect_ram

---
 rtl/fsm_lect_ram.sv | 105 ++++++++++
 tb/tb_fsm_lect_ram.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_lect_ram.sv
// Sequential RAM scanner: on a request edge, reads N_WORDS words one at a time
// and hands each one to a consumer through a valid/ready pair.
//
// state | meaning
// IDLE  | waiting for a 0->1 edge on do_it_lect_ram
// READ  | read strobe high, dir_ram = index
// WAIT  | RAM latency cycle, word captured on the closing edge
// PRES  | dat_out presented, waiting for dat_ready
// DONE  | one-cycle completion pulse
module fsm_lect_ram #(
  parameter int N_WORDS = 16,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              do_it_lect_ram,
  input  logic [DATA_W-1:0] dat_ram,
  input  logic              dat_ready,
  output logic [31:0]       dir_ram,
  output logic              r_ram_enable,
  output logic              w_ram_enable,
  output logic [DATA_W-1:0] dat_out,
  output logic              dat_valid,
  output logic              ram_to_rtc,
  output logic              done
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_PRES = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [IDX_W-1:0]    dir_q, dir_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                req_q;

  // Request history resets to 1 so a level already high at release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      dir_q   <= '0;
      dat_q   <= '0;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      dir_q   <= dir_d;
      dat_q   <= dat_d;
      req_q   <= do_it_lect_ram;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    dat_d   = dat_q;
    case (state_q)
      S_IDLE: begin
        if (do_it_lect_ram && !req_q) begin
          state_d = S_READ;
          index_d = '0;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        dat_d   = dat_ram;
        state_d = S_PRES;
      end
      S_PRES: begin
        if (dat_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Address register loads only when entering READ, otherwise holds.
    dir_d = (state_d == S_READ) ? index_d : dir_q;
  end

  always_comb begin
    r_ram_enable = (state_q == S_READ);
    w_ram_enable = 1'b0;
    dat_valid    = (state_q == S_PRES);
    done         = (state_q == S_DONE);
    ram_to_rtc   = (state_q != S_IDLE);
    dat_out      = dat_q;
    dir_ram      = {{(32 - IDX_W){1'b0}}, dir_q};
  end

endmodule

// File: tb/tb_fsm_lect_ram.sv
// Bench for fsm_lect_ram: directed scans plus random request/ready traffic,
// checked every cycle against a word/age behavioural model.
module tb_fsm_lect_ram;
  localparam int N  = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          do_it;
  logic          dat_ready;
  logic [DW-1:0] dat_ram;
  logic [31:0]   dir_ram;
  logic          r_ram_enable, w_ram_enable, dat_valid, ram_to_rtc, done;
  logic [DW-1:0] dat_out;

  logic          do1;
  logic          rdy1;
  logic [DW-1:0] dram1;
  logic [31:0]   dir1;
  logic          r1, w1, valid1, busy1, done1;
  logic [DW-1:0] dout1;

  always #5 clk = ~clk;

  fsm_lect_ram #(.N_WORDS(N), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .do_it_lect_ram(do_it), .dat_ram(dat_ram),
    .dat_ready(dat_ready), .dir_ram(dir_ram), .r_ram_enable(r_ram_enable),
    .w_ram_enable(w_ram_enable), .dat_out(dat_out), .dat_valid(dat_valid),
    .ram_to_rtc(ram_to_rtc), .done(done)
  );

  fsm_lect_ram #(.N_WORDS(1), .DATA_W(DW)) dut1 (
    .clk(clk), .reset(reset), .do_it_lect_ram(do1), .dat_ram(dram1),
    .dat_ready(rdy1), .dir_ram(dir1), .r_ram_enable(r1),
    .w_ram_enable(w1), .dat_out(dout1), .dat_valid(valid1),
    .ram_to_rtc(busy1), .done(done1)
  );

  logic [DW-1:0] mem [N];
  always @(posedge clk) if (r_ram_enable) dat_ram <= mem[dir_ram[3:0]];
  always @(posedge clk) if (r1) dram1 <= 8'h5C;

  int checks = 0;
  int passes = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Model: a scan is a sequence of words; each word ages from 0 (read strobe),
  // 1 (RAM latency) to 2+ (presented until ready).
  bit            m_prev, m_busy, m_done;
  int            m_word, m_age, m_addr;
  logic [DW-1:0] m_dout;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prev <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0;
      m_word <= 0; m_age <= 0; m_addr <= 0; m_dout <= '0;
    end else begin
      m_prev <= do_it;
      if (m_done) m_done <= 1'b0;
      else if (!m_busy) begin
        if (do_it && !m_prev) begin
          m_busy <= 1'b1; m_word <= 0; m_age <= 0; m_addr <= 0;
        end
      end else if (m_age == 0) m_age <= 1;
      else if (m_age == 1) begin
        m_dout <= mem[m_word];
        m_age  <= 2;
      end else if (dat_ready) begin
        if (m_word == N - 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
        end else begin
          m_word <= m_word + 1; m_age <= 0; m_addr <= m_word + 1;
        end
      end
    end
  end

  int            cyc = 0;
  int            addr_q[$];
  logic [DW-1:0] xfer_q[$];
  int            done_cnt, done_cyc, read_entry, busy_cyc;
  int            r1_cnt, r1_dir, r1_entry, d1_cnt, d1_cyc, b1_cyc, x1_cnt;
  logic [DW-1:0] x1_val;

  always @(negedge clk) begin
    cyc++;
    check("cmp_r_en",  r_ram_enable, m_busy && (m_age == 0));
    check("cmp_w_en",  w_ram_enable, 0);
    check("cmp_dir",   dir_ram,      m_addr);
    check("cmp_valid", dat_valid,    m_busy && (m_age >= 2));
    check("cmp_dout",  dat_out,      m_dout);
    check("cmp_busy",  ram_to_rtc,   m_busy || m_done);
    check("cmp_done",  done,         m_done);
    if (r_ram_enable) begin
      if (addr_q.size() == 0) read_entry = cyc;
      addr_q.push_back(int'(dir_ram));
    end
    if (dat_valid && dat_ready) xfer_q.push_back(dat_out);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ram_to_rtc) busy_cyc++;
    if (r1) begin r1_cnt++; r1_dir = int'(dir1); r1_entry = cyc; end
    if (valid1 && rdy1) begin x1_cnt++; x1_val = dout1; end
    if (done1) begin d1_cnt++; d1_cyc = cyc; end
    if (busy1) b1_cyc++;
  end

  task automatic clear_stats();
    addr_q.delete(); xfer_q.delete();
    done_cnt = 0; done_cyc = 0; read_entry = 0; busy_cyc = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
    check("done_timeout", done_cnt != d0, 1);
    #2;
  endtask

  task automatic wait_read(input int addr, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(r_ram_enable && dir_ram == 32'(addr)) && n < budget);
    check("read_timeout", r_ram_enable && dir_ram == 32'(addr), 1);
  endtask

  task automatic start_scan();
    do_it = 1'b0; tick(1); clear_stats(); do_it = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r_en"},  r_ram_enable, 0);
    check({tag, "_dir"},   dir_ram,      0);
    check({tag, "_dout"},  dat_out,      0);
    check({tag, "_valid"}, dat_valid,    0);
    check({tag, "_busy"},  ram_to_rtc,   0);
    check({tag, "_done"},  done,         0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    reset = 1'b0; do_it = 1'b1; dat_ready = 1'b1; do1 = 1'b0; rdy1 = 1'b1;
    r1_cnt = 0; r1_dir = -1; r1_entry = 0; d1_cnt = 0; d1_cyc = 0; b1_cyc = 0; x1_cnt = 0; x1_val = '0;
    for (int k = 0; k < N; k++) mem[k] = 8'(8'hA0 + k);
    clear_stats();
    tick(3);
    check_all_zero("rst");

    // Request already high at release must not start a scan.
    reset = 1'b1; tick(6);
    check("hi_at_release_reads", addr_q.size(), 0);
    check("hi_at_release_busy",  busy_cyc,      0);

    // Plain scan, ready always high.
    start_scan(); wait_done(120); tick(2);
    check("scan_reads", addr_q.size(), 16);
    for (int k = 0; k < addr_q.size() && k < N; k++) check("scan_addr", addr_q[k], k);
    check("scan_xfers", xfer_q.size(), 16);
    for (int k = 0; k < xfer_q.size() && k < N; k++) check("scan_data", xfer_q[k], 8'hA0 + k);
    check("scan_done_offset", done_cyc - read_entry, 48);
    check("scan_busy_cycles", busy_cyc, 49);
    check("scan_done_count",  done_cnt, 1);

    // Re-pulse mid-scan and a level held through DONE are both ignored.
    start_scan(); tick(10); do_it = 1'b0; tick(2); do_it = 1'b1;
    wait_done(120); tick(6);
    check("repulse_xfers", xfer_q.size(), 16);
    check("repulse_done",  done_cnt,      1);
    check("repulse_busy",  busy_cyc,      49);

    // Stall on word 3.
    start_scan();
    wait_read(3, 100);
    @(posedge clk); #2; dat_ready = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", dat_valid,    1);
      check("stall_dout",  dat_out,      8'hA3);
      check("stall_r_en",  r_ram_enable, 0);
      @(posedge clk); #2;
    end
    dat_ready = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check("resume_r_en", r_ram_enable, 1);
    check("resume_dir",  dir_ram,      4);
    wait_done(120); tick(2);
    check("stall_xfers", xfer_q.size(), 16);
    check("stall_word3", xfer_q.size() > 3 ? xfer_q[3] : 8'h00, 8'hA3);
    check("stall_busy",  busy_cyc, 54);

    // Reset during WAIT of word 7.
    start_scan();
    wait_read(7, 100);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check_all_zero("abort");
    tick(3); reset = 1'b1;
    held = addr_q.size();
    tick(5);
    check("abort_no_done",    done_cnt,      0);
    check("abort_no_restart", addr_q.size(), held);
    start_scan();
    wait_read(0, 20);
    wait_done(120); tick(2);
    check("restart_xfers", xfer_q.size(), 16);
    check("restart_done",  done_cnt,      1);

    // Random traffic; the per-cycle compare against the model does the checking.
    clear_stats();
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 7) == 0) do_it = ~do_it;
      dat_ready = ($urandom_range(0, 3) != 0);
      if (!ram_to_rtc && $urandom_range(0, 1) == 0) mem[$urandom_range(0, N - 1)] = 8'($urandom);
      tick(1);
    end
    check("rand_some_done", done_cnt > 0, 1);
    do_it = 1'b0; dat_ready = 1'b1;
    wait_done(200); tick(3);

    // Single-word configuration.
    do1 = 1'b1; tick(8);
    check("n1_reads",       r1_cnt,            1);
    check("n1_dir",         r1_dir,            0);
    check("n1_xfers",       x1_cnt,            1);
    check("n1_data",        x1_val,            8'h5C);
    check("n1_done_offset", d1_cyc - r1_entry, 3);
    check("n1_busy",        b1_cyc,            4);
    check("n1_done_count",  d1_cnt,            1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
